// File: rtl/rbm_vote_classifier.sv
// rtl/rbm_vote_classifier.sv - per-class vote accumulation over sampling iterations with sequential argmax
module rbm_vote_classifier #(
  parameter int output_dim      = 2,
  parameter int num_samples     = 16,
  parameter int count_bitlength = 8,
  parameter int class_bitlength = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  input  logic [output_dim-1:0]      sample_data,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic [class_bitlength-1:0] result_class,
  output logic [count_bitlength-1:0] result_count,
  output logic                       result_tie,
  output logic                       busy
);

  localparam int sample_bitlength = $clog2(num_samples + 1);
  localparam logic [sample_bitlength-1:0] last_sample = sample_bitlength'(num_samples - 1);
  localparam logic [sample_bitlength-1:0] sample_one  = sample_bitlength'(1);
  localparam logic [class_bitlength-1:0]  last_class  = class_bitlength'(output_dim - 1);
  localparam logic [class_bitlength-1:0]  class_one   = class_bitlength'(1);
  localparam logic [count_bitlength-1:0]  count_one   = count_bitlength'(1);

  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_t;

  state_t state, state_next;

  logic [count_bitlength-1:0]  cnt [output_dim];
  logic [sample_bitlength-1:0] sample_cnt;
  logic [class_bitlength-1:0]  scan_idx;
  logic [count_bitlength-1:0]  best_cnt, best_cnt_next, cur_cnt;
  logic [class_bitlength-1:0]  best_idx, best_idx_next;
  logic                        best_tie, best_tie_next;
  logic                        clear, accept, last_accept, last_scan;

  // Only a start seen in IDLE begins a classification and wipes the counters.
  assign clear       = (state == IDLE) && start;
  assign accept      = (state == ACCUM) && sample_valid;
  assign last_accept = accept && (sample_cnt == last_sample);
  assign last_scan   = (state == SCAN) && (scan_idx == last_class);
  assign cur_cnt     = cnt[scan_idx];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_next   = state;
    sample_ready = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = ACCUM;
      end
      ACCUM: begin
        sample_ready = 1'b1;
        if (last_accept) state_next = SCAN;
      end
      SCAN: begin
        if (scan_idx == last_class) state_next = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One argmax step: a strictly greater count takes over, an equal count only flags a tie.
  always_comb begin
    best_cnt_next = best_cnt;
    best_idx_next = best_idx;
    best_tie_next = best_tie;
    if (scan_idx == '0) begin
      best_cnt_next = cur_cnt;
      best_idx_next = '0;
      best_tie_next = 1'b0;
    end else if (cur_cnt > best_cnt) begin
      best_cnt_next = cur_cnt;
      best_idx_next = scan_idx;
      best_tie_next = 1'b0;
    end else if (cur_cnt == best_cnt) begin
      best_tie_next = 1'b1;
    end
  end

  // Saturating per-class vote counters; every set bit of an accepted sample votes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < output_dim; i++) cnt[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < output_dim; i++) cnt[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < output_dim; i++) begin
        if (sample_data[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + count_one;
      end
    end
  end

  // Sample counter and scan working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      scan_idx   <= '0;
      best_cnt   <= '0;
      best_idx   <= '0;
      best_tie   <= 1'b0;
    end else if (clear) begin
      sample_cnt <= '0;
      scan_idx   <= '0;
      best_cnt   <= '0;
      best_idx   <= '0;
      best_tie   <= 1'b0;
    end else begin
      if (accept) sample_cnt <= sample_cnt + sample_one;
      if (state == SCAN) begin
        best_cnt <= best_cnt_next;
        best_idx <= best_idx_next;
        best_tie <= best_tie_next;
        if (!last_scan) scan_idx <= scan_idx + class_one;
      end
    end
  end

  // Result registers load on the final scan step and hold until the next scan completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_class <= '0;
      result_count <= '0;
      result_tie   <= 1'b0;
    end else if (last_scan) begin
      result_class <= best_idx_next;
      result_count <= best_cnt_next;
      result_tie   <= best_tie_next;
    end
  end

endmodule

// File: tb/tb_rbm_vote_classifier.sv
// tb/tb_rbm_vote_classifier.sv - scoreboard bench for rbm_vote_classifier
module tb_rbm_vote_classifier;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic [1:0] sample_data = 2'b00;
  logic       result_valid;
  logic       result_ready = 1'b1;
  logic [0:0] result_class;
  logic [7:0] result_count;
  logic       result_tie;
  logic       busy;

  rbm_vote_classifier #(
    .output_dim(2), .num_samples(16), .count_bitlength(8), .class_bitlength(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_data(sample_data),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_class(result_class), .result_count(result_count), .result_tie(result_tie),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [0:0] cls;
    logic [7:0] cnt;
    logic       tie;
  } res_t;

  res_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: every completed result handshake is compared against the oldest expectation.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (rst_n && result_valid && result_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=1 required=0");
        end else begin
          e = exp_q.pop_front();
          chk("result_class", int'(result_class), int'(e.cls));
          chk("result_count", int'(result_count), int'(e.cnt));
          chk("result_tie", int'(result_tie), int'(e.tie));
        end
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_vecs(input logic [1:0] v[16], input int n, input int max_gap,
                           input int start_at);
    logic acc;
    int   g;
    int   w;
    for (int i = 0; i < n; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (g) begin
        sample_valid = 1'b0;
        sample_data  = 2'b11;
        @(posedge clk);
        #1;
      end
      sample_valid = 1'b1;
      sample_data  = v[i];
      start        = (i == start_at);
      acc = 1'b0;
      w   = 0;
      while (!acc && w < 50) begin
        @(negedge clk);
        acc = sample_ready;
        @(posedge clk);
        #1;
        start = 1'b0;
        w++;
      end
      if (!acc) chk("accept_timeout", 0, 1);
    end
    if (n == 16) begin
      sample_valid = 1'b1;
      sample_data  = 2'b01;
      @(negedge clk);
      chk("ready_drop", int'(sample_ready), 0);
      @(posedge clk);
      #1;
    end
    sample_valid = 1'b0;
    sample_data  = 2'b00;
  endtask

  task automatic wait_result(output int c);
    int w;
    w = 0;
    @(negedge clk);
    while (!result_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!result_valid) chk("result_timeout", 0, 1);
    c = cyc;
  endtask

  task automatic finish_handshake();
    @(posedge clk);
    #1;
    chk("busy_after_done", int'(busy), 0);
  endtask

  initial begin
    logic [1:0] v [16];
    int c0;
    int c;
    int w;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_sample_ready", int'(sample_ready), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_result_tie", int'(result_tie), 0);
    chk("rst_result_class", int'(result_class), 0);
    chk("rst_result_count", int'(result_count), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-rate run of 2'b10: class 1 wins 16-0, latency 1+16+2.
    for (int i = 0; i < 16; i++) v[i] = 2'b10;
    exp_q.push_back('{cls: 1'b1, cnt: 8'd16, tie: 1'b0});
    c0 = cyc;
    do_start();
    chk("busy_after_start", int'(busy), 1);
    chk("ready_after_start", int'(sample_ready), 1);
    send_vecs(v, 16, 0, -1);
    wait_result(c);
    chk("latency", c - c0, 19);
    finish_handshake();

    // Alternating 01/10: 8-8 tie resolves to class 0.
    for (int i = 0; i < 16; i++) v[i] = (i % 2 == 0) ? 2'b01 : 2'b10;
    exp_q.push_back('{cls: 1'b0, cnt: 8'd8, tie: 1'b1});
    do_start();
    send_vecs(v, 16, 0, -1);
    wait_result(c);
    finish_handshake();

    // All-zero samples: 0-0 tie.
    for (int i = 0; i < 16; i++) v[i] = 2'b00;
    exp_q.push_back('{cls: 1'b0, cnt: 8'd0, tie: 1'b1});
    do_start();
    send_vecs(v, 16, 0, -1);
    wait_result(c);
    finish_handshake();

    // All-ones samples: both classes vote every time, 16-16 tie.
    for (int i = 0; i < 16; i++) v[i] = 2'b11;
    exp_q.push_back('{cls: 1'b0, cnt: 8'd16, tie: 1'b1});
    do_start();
    send_vecs(v, 16, 0, -1);
    wait_result(c);
    finish_handshake();

    // Random gaps on sample_valid; class 1 gets 10 votes, class 0 gets 6.
    v = '{2'b10, 2'b10, 2'b01, 2'b11, 2'b10, 2'b00, 2'b10, 2'b01,
          2'b10, 2'b10, 2'b11, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01};
    exp_q.push_back('{cls: 1'b1, cnt: 8'd10, tie: 1'b0});
    do_start();
    send_vecs(v, 16, 3, -1);
    wait_result(c);
    finish_handshake();

    // Result held under backpressure for 5 cycles.
    for (int i = 0; i < 16; i++) v[i] = 2'b01;
    result_ready = 1'b0;
    exp_q.push_back('{cls: 1'b0, cnt: 8'd16, tie: 1'b0});
    do_start();
    send_vecs(v, 16, 0, -1);
    wait_result(c);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("hold_valid", int'(result_valid), 1);
      chk("hold_class", int'(result_class), 0);
      chk("hold_count", int'(result_count), 16);
      chk("hold_tie", int'(result_tie), 0);
    end
    @(posedge clk);
    #1 result_ready = 1'b1;
    finish_handshake();

    // start pulsed in ACCUM, SCAN and DONE must not disturb the classification.
    for (int i = 0; i < 16; i++) v[i] = (i < 8) ? 2'b11 : 2'b01;
    result_ready = 1'b0;
    exp_q.push_back('{cls: 1'b0, cnt: 8'd16, tie: 1'b0});
    do_start();
    send_vecs(v, 16, 0, 5);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_result(c);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1;
    chk("done_ignores_start", int'(result_valid), 1);
    result_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("idle_after_done_start", int'(busy), 0);
    @(posedge clk);
    #1;
    chk("still_idle", int'(busy), 0);

    // Reset after 7 accepted samples, then a clean run.
    for (int i = 0; i < 16; i++) v[i] = 2'b01;
    do_start();
    send_vecs(v, 7, 0, -1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_sample_ready", int'(sample_ready), 0);
    chk("abort_result_valid", int'(result_valid), 0);
    chk("abort_result_count", int'(result_count), 0);
    chk("abort_result_class", int'(result_class), 0);
    chk("abort_result_tie", int'(result_tie), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.push_back('{cls: 1'b0, cnt: 8'd16, tie: 1'b0});
    do_start();
    send_vecs(v, 16, 0, -1);
    wait_result(c);
    finish_handshake();

    w = 0;
    while (exp_q.size() != 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rbm_vote_classifier.md
# rbm_vote_classifier

Downstream stage of the RBM top: consumes the binary output-layer samples that the stochastic classification layer produces, one `output_dim`-wide vector per sampling iteration. It accumulates per-class vote counts over `num_samples` iterations, then resolves the winning class by sequential argmax. The result is presented on a valid/ready handshake.

## Interface

Parameters:
- `output_dim`, 2 — number of classes; width of each sample vector.
- `num_samples`, 16 — sampling iterations per classification; must be ≥1.
- `count_bitlength`, 8 — vote counter width; must satisfy 2^`count_bitlength` − 1 ≥ `num_samples`.
- `class_bitlength`, 1 — result index width; max(1, $clog2(`output_dim`)).

Ports:
- `clk` input 1 — sole clock, rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `start` input 1 — begin a new classification; honoured only in IDLE.
- `sample_valid` input 1 — `sample_data` is valid.
- `sample_ready` output 1 — block accepts a sample this cycle.
- `sample_data` input `output_dim` — binary output-layer sample; bit i = class i fired.
- `result_valid` output 1 — result fields are valid.
- `result_ready` input 1 — consumer takes the result.
- `result_class` output `class_bitlength` — winning class index.
- `result_count` output `count_bitlength` — vote count of the winning class.
- `result_tie` output 1 — another class has the same count as the winner.
- `busy` output 1 — high in every state except IDLE.

## Operation

- The block has four states: IDLE, ACCUM, SCAN and DONE.
- IDLE:
  - `sample_ready` = 0.
  - `start` = 1 clears all vote counters, the sample counter and the scan registers, then moves to ACCUM.
- ACCUM:
  - `sample_ready` = 1.
  - A sample is accepted when `sample_valid` & `sample_ready`.
  - On accept, every counter i with `sample_data`[i] = 1 increments. Several bits may be set at once; all of them count. An all-zero sample counts as an iteration but adds no votes.
  - The sample counter increments on each accept. The accept that makes the total equal `num_samples` moves the block to SCAN, with `sample_ready` low from the next cycle.
  - Vote counters saturate at all-ones and never wrap.
- SCAN:
  - Examines one class per cycle, index 0 to `output_dim` − 1.
  - Index 0 loads best = cnt[0], idx = 0, tie = 0.
  - For later indices: if cnt[i] > best, then best = cnt[i], idx = i, tie = 0. Else if cnt[i] == best, then tie = 1.
  - Ties therefore resolve to the lowest index, with the flag set.
  - After index `output_dim` − 1 the block moves to DONE.
- DONE:
  - `result_valid` = 1. `result_class`, `result_count` and `result_tie` are registered and held stable.
  - `result_valid` & `result_ready` returns the block to IDLE.
  - Result fields keep their values until the next SCAN overwrites them; only `result_valid` drops.
- `start` outside IDLE is ignored, with no restart and no counter clear.
- `sample_valid` outside ACCUM is ignored; nothing is accepted.

## Timing

- Reset (async assert, `rst_n` = 0):
  - State returns to IDLE.
  - `sample_ready`, `result_valid`, `busy` and `result_tie` are 0; `result_class` and `result_count` are 0.
  - All counters are cleared.
  - Reset mid-ACCUM or mid-SCAN discards the partial classification.
- `start` sampled at edge t: `busy` and `sample_ready` are high from t+1.
- Sample throughput: one per cycle at full rate. Minimum ACCUM duration is `num_samples` cycles.
- Last sample accepted at edge k: SCAN occupies cycles k+1 … k+`output_dim`, and `result_valid` rises after edge k+`output_dim`.
- Total latency from `start` to `result_valid` at full sample rate: 1 + `num_samples` + `output_dim` cycles.
- `result_ready` held high when `result_valid` rises: result is consumed in 1 cycle, and IDLE (`busy` = 0) follows the next edge.
- `start` asserted in the same cycle the DONE handshake completes is ignored; a new `start` is needed in IDLE.

## Test plan

- Defaults, `start`, then 16 samples of 2'b10 back-to-back → `result_class` = 1, `result_count` = 16, `result_tie` = 0; `result_valid` high 1+16+2 cycles after `start`.
- 16 samples alternating 2'b01 / 2'b10 → `result_class` = 0, `result_count` = 8, `result_tie` = 1.
- 16 samples of 2'b00 → class 0, count 0, tie 1; then 16 samples of 2'b11 → class 0, count 16, tie 1.
- Backpressure:
  - Random gaps on `sample_valid`: exactly 16 accepts occur before `sample_ready` drops, and votes match the accepted vectors only.
  - `result_ready` held low 5 cycles: result fields stay stable, and `result_valid` stays high until the handshake.
- `start` pulsed during ACCUM, SCAN and DONE: ignored. The counts of the in-flight classification are unchanged.
- `rst_n` asserted after 7 accepted samples:
  - All outputs are 0 and the state is IDLE.
  - A following full run of 16 × 2'b01 yields class 0, count 16 (no residue from the aborted run).
